// File: rtl/apb_master_pkg.sv
// Types and default widths shared by the APB master and the APB slave.
package apb_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic                      write;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0]      wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master_wait_timer.sv
// ACCESS wait timer for apb_master: a loadable up-counter with an expire flag.
// Present only when APB_MASTER_TIMEOUT_EN is defined.
`ifdef APB_MASTER_TIMEOUT_EN
module apb_wait_timer #(
  parameter int LIMIT = 16,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic expire
);

  logic [CW-1:0] count;

  // Expire on the increment that would bring the count up to LIMIT.
  assign expire = inc && (count == CW'(LIMIT - 1));

  // Wait-cycle counter: cleared by load, advanced by inc.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {CW{1'b0}};
    end else if (load) begin
      count <= {CW{1'b0}};
    end else if (inc) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

endmodule
`endif

// File: rtl/apb_master.sv
// APB3 requester: one command at a time through IDLE -> SETUP -> ACCESS, single-entry response.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master
  import apb_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [WIDTH-1:0]      pwdata,
  input  logic [WIDTH-1:0]      prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  state_t                  state, next_state;
  logic                    accept, timer_expire;
  logic                    n_psel, n_penable, n_pwrite;
  logic [ADDR_WIDTH-1:0]   n_paddr;
  logic [WIDTH-1:0]        n_pwdata, n_rsp_rdata;
  logic                    n_rsp_valid, n_rsp_err, n_rsp_timeout;

  assign cmd_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
    .clk    (pclk),
    .rst    (preset),
    .load   (state == SETUP),
    .inc    ((state == ACCESS) && !pready),
    .expire (timer_expire)
  );
`else
  assign timer_expire = 1'b0;
`endif

  // Next state and next values of every registered bus/response output.
  always_comb begin
    next_state    = state;
    n_psel        = psel;
    n_penable     = penable;
    n_pwrite      = pwrite;
    n_paddr       = paddr;
    n_pwdata      = pwdata;
    n_rsp_valid   = rsp_valid && !rsp_ready;
    n_rsp_rdata   = rsp_rdata;
    n_rsp_err     = rsp_err;
    n_rsp_timeout = rsp_timeout;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = SETUP;
          n_psel     = 1'b1;
          n_penable  = 1'b0;
          n_paddr    = cmd_addr;
          n_pwrite   = cmd_write;
          n_pwdata   = cmd_write ? cmd_wdata : {WIDTH{1'b0}};
        end else begin
          next_state = IDLE;
        end
      end
      SETUP: begin
        next_state = ACCESS;
        n_penable  = 1'b1;
      end
      ACCESS: begin
        // pready wins over a timeout expiring on the same edge.
        if (pready) begin
          next_state    = IDLE;
          n_psel        = 1'b0;
          n_penable     = 1'b0;
          n_rsp_valid   = 1'b1;
          n_rsp_rdata   = pwrite ? {WIDTH{1'b0}} : prdata;
          n_rsp_err     = pslverr;
          n_rsp_timeout = 1'b0;
        end else if (timer_expire) begin
          next_state    = IDLE;
          n_psel        = 1'b0;
          n_penable     = 1'b0;
          n_rsp_valid   = 1'b1;
          n_rsp_rdata   = {WIDTH{1'b0}};
          n_rsp_err     = 1'b1;
          n_rsp_timeout = 1'b1;
        end else begin
          next_state = ACCESS;
        end
      end
      default: begin
        next_state = IDLE;
        n_psel     = 1'b0;
        n_penable  = 1'b0;
      end
    endcase
  end

  // State register and registered outputs; reset drops the bus and any pending response.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= {ADDR_WIDTH{1'b0}};
      pwdata      <= {WIDTH{1'b0}};
      rsp_valid   <= 1'b0;
      rsp_rdata   <= {WIDTH{1'b0}};
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= next_state;
      psel        <= n_psel;
      penable     <= n_penable;
      pwrite      <= n_pwrite;
      paddr       <= n_paddr;
      pwdata      <= n_pwdata;
      rsp_valid   <= n_rsp_valid;
      rsp_rdata   <= n_rsp_rdata;
      rsp_err     <= n_rsp_err;
      rsp_timeout <= n_rsp_timeout;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: behavioural APB slave, transaction-level model, per-cycle compare.
module tb_apb_master;

  localparam int TO = 4;

  logic        pclk = 1'b0, preset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [31:0] cmd_wdata = 32'h0;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [7:0]  paddr;

  int checks = 0, errors = 0;
  int cyc = 0, cur_w = 0, rdy_mode = 2, last_acc = 0;

  apb_master #(.WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Slave: 256 words, errors on addr[7], pready after w_lat wait cycles, junk elsewhere.
  logic [31:0] mem [256];
  logic [31:0] junk = 32'h0;
  int          wcnt = 0, w_lat = 0;
  assign pready  = penable ? (psel && (wcnt >= w_lat)) : junk[1];
  assign pslverr = pready ? paddr[7] : junk[0];
  assign prdata  = pready ? (paddr[7] ? 32'h0 : mem[paddr]) : junk;

  always @(posedge pclk) begin
    junk <= $urandom;
    if (psel && !penable) w_lat <= cur_w;
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (psel && penable && pready && pwrite && !pslverr) mem[paddr] <= pwdata;
  end

  // Transaction model: one transfer in flight, response at accept + 1 + ACCESS length.
  logic [31:0] model_mem [256];
  bit          started = 1'b0, busy = 1'b0, pend = 1'b0;
  int          acc_edge = 0, acc_w = 0;
  bit          acc_write = 1'b0;
  logic [7:0]  acc_addr = 8'h00;
  logic [31:0] acc_wdata = 32'h0, exp_rdata = 32'h0;
  bit          exp_err = 1'b0, exp_to = 1'b0;

  function automatic bit timed_out(int w);
`ifdef APB_MASTER_TIMEOUT_EN
    return w >= TO;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int access_len(int w);
    return timed_out(w) ? TO : w + 1;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]       <= {4{i[7:0]}};
      model_mem[i] <= {4{i[7:0]}};
    end
  end

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (preset) begin
      started <= 1'b1;
      busy    <= 1'b0;
      pend    <= 1'b0;
    end else begin
      if (pend && rsp_ready) pend <= 1'b0;
      if (busy && (cyc + 1 == acc_edge + 1 + access_len(acc_w))) begin
        busy <= 1'b0;
        pend <= 1'b1;
        if (timed_out(acc_w)) begin
          exp_rdata <= 32'h0;
          exp_err   <= 1'b1;
          exp_to    <= 1'b1;
        end else begin
          exp_err   <= acc_addr[7];
          exp_to    <= 1'b0;
          exp_rdata <= (acc_write || acc_addr[7]) ? 32'h0 : model_mem[acc_addr];
          if (acc_write && !acc_addr[7]) model_mem[acc_addr] <= acc_wdata;
        end
      end
      if (cmd_valid && !busy && (!pend || rsp_ready)) begin
        busy      <= 1'b1;
        acc_edge  <= cyc + 1;
        acc_w     <= cur_w;
        acc_write <= cmd_write;
        acc_addr  <= cmd_addr;
        acc_wdata <= cmd_wdata;
      end
    end
  end

  // Every cycle after the first reset edge: bus and response outputs versus the model.
  always @(negedge pclk) begin
    if (started) begin
      chk("psel", {31'h0, psel}, {31'h0, busy});
      chk("penable", {31'h0, penable}, {31'h0, busy && (cyc > acc_edge)});
      if (busy) begin
        chk("paddr", {24'h0, paddr}, {24'h0, acc_addr});
        chk("pwrite", {31'h0, pwrite}, {31'h0, acc_write});
        chk("pwdata", pwdata, acc_write ? acc_wdata : 32'h0);
      end
      chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, pend});
      if (pend) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
        chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, exp_to});
      end
      chk("cmd_ready", {31'h0, cmd_ready}, {31'h0, !busy && (!pend || rsp_ready)});
    end
  end

  // Response consumer: random, always-low or always-high rsp_ready.
  initial begin
    forever begin
      @(posedge pclk);
      #1;
      if (rdy_mode == 0) rsp_ready = 1'($urandom % 2);
      else rsp_ready = (rdy_mode == 2);
    end
  end

  task automatic issue(bit wr, logic [7:0] a, logic [31:0] d, int w);
    bit ok = 1'b0;
    int n = 0;
    cur_w = w; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    do begin
      @(negedge pclk);
      ok = cmd_ready;
      @(posedge pclk);
      #1;
      n++;
    end while (!ok && n < 300);
    last_acc = cyc;
    cmd_valid = 1'b0; cmd_addr = 8'($urandom); cmd_wdata = $urandom;
    if (!ok) chk("accept_bound", 32'h0, 32'h1);
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_rsp(output int lat, output logic [31:0] rd, output bit er, output bit tmo);
    int n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!rsp_valid && n < 300);
    if (!rsp_valid) chk("rsp_bound", 32'h0, 32'h1);
    lat = cyc - last_acc; rd = rsp_rdata; er = rsp_err; tmo = rsp_timeout;
    @(posedge pclk);
    #1;
  endtask

  int          lat;
  logic [31:0] rd;
  bit          er, tmo;
  logic [7:0]  ra;

  initial begin
    repeat (3) @(posedge pclk);
    #1;
    preset = 1'b0;
    chk("rst_psel", {31'h0, psel}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_paddr", {24'h0, paddr}, 32'h0);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    issue(1'b1, 8'h10, 32'hDEADBEEF, 1);
    wait_rsp(lat, rd, er, tmo);
    chk("wr_latency", lat, 32'd3);
    chk("wr_rdata", rd, 32'h0);
    chk("wr_err", {31'h0, er}, 32'h0);

    issue(1'b0, 8'h10, 32'h0, 2);
    wait_rsp(lat, rd, er, tmo);
    chk("rd_latency", lat, 32'd4);
    chk("rd_rdata", rd, 32'hDEADBEEF);

    issue(1'b0, 8'h80, 32'h0, 0);
    wait_rsp(lat, rd, er, tmo);
    chk("err80_err", {31'h0, er}, 32'h1);
    chk("err80_timeout", {31'h0, tmo}, 32'h0);
    issue(1'b0, 8'h7F, 32'h0, 0);
    wait_rsp(lat, rd, er, tmo);
    chk("rd7f_err", {31'h0, er}, 32'h0);
    chk("rd7f_rdata", rd, 32'h7F7F7F7F);

    // Response held with a command pending, then accepted on the consuming edge.
    rdy_mode = 1; rsp_ready = 1'b0;
    issue(1'b1, 8'h30, 32'h12345678, 0);
    wait_rsp(lat, rd, er, tmo);
    cur_w = 0; cmd_write = 1'b0; cmd_addr = 8'h30; cmd_valid = 1'b1;
    repeat (5) begin
      @(negedge pclk);
      chk("stall_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      @(posedge pclk);
      #1;
    end
    rdy_mode = 2; rsp_ready = 1'b1;
    @(negedge pclk);
    chk("release_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    @(posedge pclk);
    #1;
    last_acc = cyc; cmd_valid = 1'b0;
    chk("release_setup", {30'h0, psel, penable}, 32'h2);
    wait_rsp(lat, rd, er, tmo);
    chk("release_rdata", rd, 32'h12345678);

    // Reset during ACCESS of a write: bus drops, memory untouched.
    issue(1'b1, 8'h20, 32'hCAFEF00D, 5);
    @(posedge pclk);
    #1;
    preset = 1'b1;
    @(posedge pclk);
    #1;
    preset = 1'b0;
    chk("midrst_bus", {30'h0, psel, penable}, 32'h0);
    chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    issue(1'b0, 8'h20, 32'h0, 0);
    wait_rsp(lat, rd, er, tmo);
    chk("midrst_mem", rd, 32'h20202020);

`ifdef APB_MASTER_TIMEOUT_EN
    issue(1'b0, 8'h05, 32'h0, 1000);
    wait_rsp(lat, rd, er, tmo);
    chk("to_latency", lat, 32'd5);
    chk("to_flags", {30'h0, er, tmo}, 32'h3);
    chk("to_rdata", rd, 32'h0);
`else
    issue(1'b0, 8'h05, 32'h0, 1000);
    repeat (100) begin
      @(negedge pclk);
      chk("hold_psel", {31'h0, psel}, 32'h1);
    end
    @(posedge pclk);
    #1;
    preset = 1'b1;
    @(posedge pclk);
    #1;
    preset = 1'b0;
`endif

    rdy_mode = 0;
    for (int k = 0; k < 80; k++) begin
      ra = 8'($urandom_range(0, 7)) | (($urandom % 4 == 0) ? 8'h80 : 8'h00);
      issue(1'($urandom % 2), ra, $urandom, $urandom_range(0, 6));
    end
    rdy_mode = 2;
    repeat (20) @(posedge pclk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
